bsg_one_fifo_rr_arb: RTL and testbench



---
 rtl/bsg_one_fifo_rr_arb.sv | 109 ++++++++++
 tb/tb_bsg_one_fifo_rr_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_one_fifo_rr_arb.sv
// Round-robin arbiter over els_p valid/ready producers feeding a one-entry valid/yumi buffer.
// Define BSG_ONE_FIFO_RR_ARB_BYPASS_EN to present the winner on the output in the grant cycle.
module bsg_one_fifo_rr_arb #(
  parameter int unsigned width_p = 16,
  parameter int unsigned els_p   = 4,
  localparam int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [lg_els_lp-1:0]       tag_o,
  input  logic                       yumi_i
);

  logic                 full_q, full_d;
  logic [lg_els_lp-1:0] last_q, last_d;
  logic [width_p-1:0]   data_q;
  logic [lg_els_lp-1:0] tag_q;

  logic                 grant_found;
  logic [lg_els_lp-1:0] grant_idx;
  logic [width_p-1:0]   grant_data;
  logic                 arb_en;
  logic                 handshake;
  logic                 enq;
  logic                 deq;

  // Search starts just past the last winner and wraps modulo els_p.
  always_comb begin : grant_search
    int unsigned          idx;
    logic [lg_els_lp-1:0] idx_t;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_t       = '0;
    for (int unsigned off = 1; off <= els_p; off++) begin
      idx   = (32'(last_q) + off) % els_p;
      idx_t = lg_els_lp'(idx);
      if (!grant_found && v_i[idx_t]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t;
      end
    end
  end

  assign grant_data = data_i[32'(grant_idx)*width_p +: width_p];
  assign arb_en     = !full_q && !reset_i;
  assign handshake  = arb_en && grant_found;
  assign deq        = full_q && yumi_i;

  always_comb begin
    ready_o = '0;
    if (handshake) begin
      ready_o[grant_idx] = 1'b1;
    end
  end

`ifdef BSG_ONE_FIFO_RR_ARB_BYPASS_EN
  // An empty buffer forwards the winner; it is captured only if the consumer declines it.
  assign v_o    = full_q || handshake;
  assign data_o = full_q ? data_q : grant_data;
  assign tag_o  = full_q ? tag_q  : grant_idx;
  assign enq    = handshake && !yumi_i;
`else
  assign v_o    = full_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;
  assign enq    = handshake;
`endif

  always_comb begin
    full_d = full_q;
    if (enq) begin
      full_d = 1'b1;
    end else if (deq) begin
      full_d = 1'b0;
    end
  end

  assign last_d = handshake ? grant_idx : last_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      last_q <= lg_els_lp'(els_p - 1);
    end else begin
      full_q <= full_d;
      last_q <= last_d;
    end
  end

  // Payload and tag are don't-care while empty, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_q <= grant_data;
      tag_q  <= grant_idx;
    end
  end

`ifndef SYNTHESIS
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("bsg_one_fifo_rr_arb: yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_one_fifo_rr_arb.sv
// Directed bench for bsg_one_fifo_rr_arb (width_p=16, els_p=4), table-driven plus corner sequences.
module tb_bsg_one_fifo_rr_arb;

`ifdef BSG_ONE_FIFO_RR_ARB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  v_i;
  logic [63:0] data_i;
  logic [3:0]  ready_o;
  logic        v_o;
  logic [15:0] data_o;
  logic [1:0]  tag_o;
  logic        yumi_i;

  int n_vec  = 0;
  int n_miss = 0;

  bsg_one_fifo_rr_arb #(.width_p(16), .els_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .tag_o   (tag_o),
    .yumi_i  (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] v;
    logic       yumi;
    logic [3:0] ready;
    logic       vo;
    logic [1:0] tag;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] val);
    data_i[i*16 +: 16] = val;
  endtask

  function automatic logic [15:0] rr_data(input logic [1:0] i);
    return 16'hC0D0 + 16'(i);
  endfunction

  initial begin
    logic exp_v;

    // Round robin from reset pointer: grant cycle, then consume cycle.
    tbl[0]  = '{4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b0, 4'b0010, 1'b0, 2'd1};
    tbl[3]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[4]  = '{4'hF, 1'b0, 4'b0100, 1'b0, 2'd2};
    tbl[5]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[6]  = '{4'hF, 1'b0, 4'b1000, 1'b0, 2'd3};
    tbl[7]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[8]  = '{4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[9]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[10] = '{4'hF, 1'b0, 4'b0010, 1'b0, 2'd1};
    tbl[11] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd1};

    reset_i = 1'b1;
    v_i     = 4'hF;
    data_i  = '0;
    yumi_i  = 1'b0;
    #2;
    chk("reset_v_o", 32'(v_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    v_i     = 4'b0000;
    tick();

    // Single requester
    v_i = 4'b0100;
    set_data(2, 16'hBEEF);
    #1;
    chk("single_ready", 32'(ready_o), 32'b0100);
    chk("single_v_pre", 32'(v_o), 32'(Byp));
    tick();
    v_i = 4'b0000;
    #1;
    chk("single_v_o", 32'(v_o), 32'd1);
    chk("single_data", 32'(data_o), 32'hBEEF);
    chk("single_tag", 32'(tag_o), 32'd2);
    chk("single_ready_full", 32'(ready_o), 32'd0);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    chk("single_drain", 32'(v_o), 32'd0);

    // Async reset while full with tag 2
    v_i = 4'b0100;
    tick();
    v_i = 4'b0000;
    #1;
    chk("areset_pre_v", 32'(v_o), 32'd1);
    chk("areset_pre_tag", 32'(tag_o), 32'd2);
    #1;
    reset_i = 1'b1;
    v_i     = 4'b0011;
    #1;
    chk("areset_v_o", 32'(v_o), 32'd0);
    chk("areset_ready", 32'(ready_o), 32'd0);
    #1;
    reset_i = 1'b0;
    #1;
    chk("areset_release_ready", 32'(ready_o), 32'b0001);
    v_i = 4'b0000;
    tick();

    // Table-driven round robin
    for (int i = 0; i < 4; i++) set_data(i, rr_data(2'(i)));
    for (int k = 0; k < 12; k++) begin
      v_i    = tbl[k].v;
      yumi_i = tbl[k].yumi;
      #1;
      exp_v = tbl[k].vo | (Byp && (tbl[k].ready != 4'b0000));
      chk($sformatf("rr%0d_ready", k), 32'(ready_o), 32'(tbl[k].ready));
      chk($sformatf("rr%0d_v_o", k), 32'(v_o), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("rr%0d_tag", k), 32'(tag_o), 32'(tbl[k].tag));
        chk($sformatf("rr%0d_data", k), 32'(data_o), 32'(rr_data(tbl[k].tag)));
      end
      tick();
    end
    v_i    = 4'b0000;
    yumi_i = 1'b0;

    // Fairness skip: move pointer to 3, then 4'b1010 grants 1 then 3
    v_i = 4'b1000;
    #1;
    chk("fair_setup_ready", 32'(ready_o), 32'b1000);
    tick();
    v_i    = 4'b0000;
    yumi_i = 1'b1;
    #1;
    chk("fair_setup_tag", 32'(tag_o), 32'd3);
    tick();
    yumi_i = 1'b0;
    v_i    = 4'b1010;
    #1;
    chk("fair_first_ready", 32'(ready_o), 32'b0010);
    tick();
    v_i    = 4'b1000;
    yumi_i = 1'b1;
    #1;
    chk("fair_first_tag", 32'(tag_o), 32'd1);
    chk("fair_full_ready", 32'(ready_o), 32'd0);
    tick();
    yumi_i = 1'b0;
    #1;
    chk("fair_second_ready", 32'(ready_o), 32'b1000);
    tick();
    v_i    = 4'b0000;
    yumi_i = 1'b1;
    #1;
    chk("fair_second_tag", 32'(tag_o), 32'd3);
    tick();
    yumi_i = 1'b0;

    // Backpressure: hold yumi low for 5 cycles with all others requesting
    set_data(1, 16'h00A5);
    v_i = 4'b0010;
    #1;
    chk("bp_grant", 32'(ready_o), 32'b0010);
    tick();
    v_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_v_o", c), 32'(v_o), 32'd1);
      chk($sformatf("bp%0d_data", c), 32'(data_o), 32'h00A5);
      chk($sformatf("bp%0d_tag", c), 32'(tag_o), 32'd1);
      chk($sformatf("bp%0d_ready", c), 32'(ready_o), 32'd0);
      tick();
    end
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    chk("bp_pointer_kept", 32'(ready_o), 32'b0100);
    v_i = 4'b0000;
    tick();

    // Bypass / registered latency with requester 1
    set_data(1, 16'h1234);
    v_i = 4'b0010;
`ifdef BSG_ONE_FIFO_RR_ARB_BYPASS_EN
    yumi_i = 1'b1;
    #1;
    chk("byp_v_o", 32'(v_o), 32'd1);
    chk("byp_data", 32'(data_o), 32'h1234);
    chk("byp_tag", 32'(tag_o), 32'd1);
    chk("byp_ready", 32'(ready_o), 32'b0010);
    tick();
    v_i    = 4'b0000;
    yumi_i = 1'b0;
    #1;
    chk("byp_after_empty", 32'(v_o), 32'd0);
`else
    #1;
    chk("lat_v_pre", 32'(v_o), 32'd0);
    chk("lat_ready", 32'(ready_o), 32'b0010);
    tick();
    v_i = 4'b0000;
    #1;
    chk("lat_v_o", 32'(v_o), 32'd1);
    chk("lat_data", 32'(data_o), 32'h1234);
    chk("lat_tag", 32'(tag_o), 32'd1);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    chk("lat_drain", 32'(v_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
